// File: rtl/pc_pkg.sv
// Shared decoder codes, FSM state type and target-selection helper for the PC sequencer.
package pc_pkg;

    localparam int unsigned CODE_W = 7;

    localparam logic [CODE_W-1:0] CODE_BEQ    = 7'd30;
    localparam logic [CODE_W-1:0] CODE_BGEZ   = 7'd31;
    localparam logic [CODE_W-1:0] CODE_BGEZAL = 7'd32;
    localparam logic [CODE_W-1:0] CODE_BGTZ   = 7'd33;
    localparam logic [CODE_W-1:0] CODE_BLEZ   = 7'd34;
    localparam logic [CODE_W-1:0] CODE_BLTZ   = 7'd35;
    localparam logic [CODE_W-1:0] CODE_BLTZAL = 7'd36;
    localparam logic [CODE_W-1:0] CODE_BNE    = 7'd37;
    localparam logic [CODE_W-1:0] CODE_J      = 7'd38;
    localparam logic [CODE_W-1:0] CODE_JAL    = 7'd39;
    localparam logic [CODE_W-1:0] CODE_JALR   = 7'd40;
    localparam logic [CODE_W-1:0] CODE_JR     = 7'd41;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC1  = 2'd1,
        EXEC2  = 2'd2,
        HALTED = 2'd3
    } pc_state_e;

    typedef enum logic [1:0] {
        TGT_BRANCH = 2'd0,
        TGT_JUMP   = 2'd1,
        TGT_REG    = 2'd2
    } tgt_kind_e;

    // Which target source a control op uses; non-control ops default to the branch adder.
    function automatic tgt_kind_e tgt_kind(input logic [CODE_W-1:0] code);
        tgt_kind_e kind;
        kind = TGT_BRANCH;
        if (code == CODE_J || code == CODE_JAL) begin
            kind = TGT_JUMP;
        end else if (code == CODE_JR || code == CODE_JALR) begin
            kind = TGT_REG;
        end
        return kind;
    endfunction

endpackage

// File: rtl/pc_branch_cond.sv
// Classifies the decoder op and evaluates its branch condition against the ALU flags.
module pc_branch_cond
    import pc_pkg::*;
(
    input  logic [CODE_W-1:0] internal_code,
    input  logic              zero,
    input  logic              positive,
    input  logic              negative,
    output logic              is_ctrl,
    output logic              is_link,
    output logic              cond_met
);

    always_comb begin
        is_ctrl  = 1'b1;
        is_link  = 1'b0;
        cond_met = 1'b0;
        case (internal_code)
            CODE_BEQ:    cond_met = zero;
            CODE_BNE:    cond_met = ~zero;
            CODE_BGEZ:   cond_met = positive | zero;
            CODE_BGEZAL: begin
                cond_met = positive | zero;
                is_link  = 1'b1;
            end
            CODE_BGTZ:   cond_met = positive;
            CODE_BLEZ:   cond_met = negative | zero;
            CODE_BLTZ:   cond_met = negative;
            CODE_BLTZAL: begin
                cond_met = negative;
                is_link  = 1'b1;
            end
            CODE_J,
            CODE_JR:     cond_met = 1'b1;
            CODE_JAL,
            CODE_JALR:   begin
                cond_met = 1'b1;
                is_link  = 1'b1;
            end
            default:     is_ctrl = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch/exec1/exec2 phase sequencer with stall, halt and
// optional MIPS branch-delay-slot redirect.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'hBFC00000),
    parameter logic [ADDR_W-1:0] HALT_ADDR    = ADDR_W'(32'h00000000),
    parameter bit                DELAY_SLOT   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [CODE_W-1:0] internal_code,
    input  logic [15:0]       offset,
    input  logic [25:0]       instr_index,
    input  logic [ADDR_W-1:0] register_data,
    input  logic              zero,
    input  logic              positive,
    input  logic              negative,
    output logic [ADDR_W-1:0] address,
    output logic              fetch,
    output logic              exec1,
    output logic              exec2,
    output logic              halt,
    output logic              taken,
    output logic [ADDR_W-1:0] link_addr
);

    localparam int unsigned OFF_W = 16;

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic              pend_valid_q, pend_valid_d;
    logic              taken_q, taken_d;
    logic [ADDR_W-1:0] link_q, link_d;
    logic              halt_q, halt_d;
    logic              fetch_q, fetch_d;
    logic              exec1_q, exec1_d;
    logic              exec2_q, exec2_d;

    logic              is_ctrl, is_link, cond_met;
    logic [ADDR_W-1:0] pc_plus4, pc_plus8;
    logic [ADDR_W-1:0] branch_target, jump_target, target_c;

    pc_branch_cond u_branch_cond (
        .internal_code (internal_code),
        .zero          (zero),
        .positive      (positive),
        .negative      (negative),
        .is_ctrl       (is_ctrl),
        .is_link       (is_link),
        .cond_met      (cond_met)
    );

    // Target candidates for the instruction whose address is held in address_q.
    assign pc_plus4      = address_q + ADDR_W'(4);
    assign pc_plus8      = address_q + ADDR_W'(8);
    assign branch_target = pc_plus4 + ({{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset} << 2);
    assign jump_target   = {pc_plus4[ADDR_W-1:28], instr_index, 2'b00};

    always_comb begin
        target_c = branch_target;
        case (tgt_kind(internal_code))
            TGT_JUMP: target_c = jump_target;
            TGT_REG:  target_c = register_data;
            default:  target_c = branch_target;
        endcase
    end

    // Next-state, address update and registered-output logic.
    always_comb begin
        state_d       = state_q;
        address_d     = address_q;
        target_d      = target_q;
        pend_target_d = pend_target_q;
        pend_valid_d  = pend_valid_q;
        taken_d       = taken_q;
        link_d        = link_q;
        halt_d        = halt_q;
        if (!stall) begin
            case (state_q)
                FETCH: begin
                    if (address_q == HALT_ADDR) begin
                        state_d = HALTED;
                        halt_d  = 1'b1;
                    end else begin
                        state_d = EXEC1;
                    end
                end
                EXEC1: begin
                    state_d  = EXEC2;
                    taken_d  = is_ctrl & cond_met;
                    target_d = target_c;
                    if (is_link) begin
                        link_d = DELAY_SLOT ? pc_plus8 : pc_plus4;
                    end
                end
                EXEC2: begin
                    state_d = FETCH;
                    taken_d = 1'b0;
                    if (DELAY_SLOT) begin
                        // The older pending redirect is consumed before this one is queued.
                        address_d     = pend_valid_q ? pend_target_q : pc_plus4;
                        pend_valid_d  = taken_q;
                        pend_target_d = target_q;
                    end else begin
                        address_d = taken_q ? target_q : pc_plus4;
                    end
                end
                HALTED: state_d = HALTED;
                default: state_d = FETCH;
            endcase
        end
        fetch_d = (state_d == FETCH);
        exec1_d = (state_d == EXEC1);
        exec2_d = (state_d == EXEC2);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= FETCH;
            address_q     <= RESET_VECTOR;
            target_q      <= '0;
            pend_target_q <= '0;
            pend_valid_q  <= 1'b0;
            taken_q       <= 1'b0;
            link_q        <= '0;
            halt_q        <= 1'b0;
            fetch_q       <= 1'b1;
            exec1_q       <= 1'b0;
            exec2_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            target_q      <= target_d;
            pend_target_q <= pend_target_d;
            pend_valid_q  <= pend_valid_d;
            taken_q       <= taken_d;
            link_q        <= link_d;
            halt_q        <= halt_d;
            fetch_q       <= fetch_d;
            exec1_q       <= exec1_d;
            exec2_q       <= exec2_d;
        end
    end

    assign address   = address_q;
    assign fetch     = fetch_q;
    assign exec1     = exec1_q;
    assign exec2     = exec2_q;
    assign halt      = halt_q;
    assign taken     = taken_q;
    assign link_addr = link_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Drives a delay-slot and a no-delay-slot pc_sequencer with shared stimulus and
// compares both against an instruction-level reference model every cycle.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'hBFC00000;
    localparam logic [6:0] C_NOP = 7'd0,  C_BEQ = 7'd30, C_BNE = 7'd37;
    localparam logic [6:0] C_JAL = 7'd39, C_JR  = 7'd41;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [6:0]  internal_code;
    logic [15:0] offset;
    logic [25:0] instr_index;
    logic [31:0] register_data;
    logic        zero, positive, negative;

    logic [31:0] address0, link0, address1, link1;
    logic        fetch0, exec10, exec20, halt0, taken0;
    logic        fetch1, exec11, exec21, halt1, taken1;

    int n_checks = 0;
    int n_errors = 0;
    logic last_taken0;

    // Reference model: phase per instance, current pc, and a delay line of redirects.
    int          m_phase [2];
    logic [31:0] m_pc    [2];
    logic [31:0] m_tgt   [2];
    logic [31:0] m_link  [2];
    logic        m_taken [2];
    logic        m_halt  [2];
    longint      rq      [2][$];

    pc_sequencer #(.DELAY_SLOT(1'b1)) dut_ds1 (
        .clk(clk), .reset(reset), .stall(stall), .internal_code(internal_code),
        .offset(offset), .instr_index(instr_index), .register_data(register_data),
        .zero(zero), .positive(positive), .negative(negative),
        .address(address0), .fetch(fetch0), .exec1(exec10), .exec2(exec20),
        .halt(halt0), .taken(taken0), .link_addr(link0)
    );

    pc_sequencer #(.DELAY_SLOT(1'b0)) dut_ds0 (
        .clk(clk), .reset(reset), .stall(stall), .internal_code(internal_code),
        .offset(offset), .instr_index(instr_index), .register_data(register_data),
        .zero(zero), .positive(positive), .negative(negative),
        .address(address1), .fetch(fetch1), .exec1(exec11), .exec2(exec21),
        .halt(halt1), .taken(taken1), .link_addr(link1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cond_taken(input logic [6:0] code, input logic z, input logic p, input logic n);
        case (code)
            7'd30: return z;
            7'd37: return !z;
            7'd31, 7'd32: return p || z;
            7'd33: return p;
            7'd34: return n || z;
            7'd35, 7'd36: return n;
            7'd38, 7'd39, 7'd40, 7'd41: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] target_of(input logic [6:0] code, input logic [31:0] pc,
                                              input logic [15:0] off, input logic [25:0] idx,
                                              input logic [31:0] rd);
        int soff;
        soff = $signed(off);
        case (code)
            7'd40, 7'd41: return rd;
            7'd38, 7'd39: return ((pc + 32'd4) & 32'hF0000000) | ({6'd0, idx} * 32'd4);
            default:      return pc + 32'd4 + 32'(soff * 4);
        endcase
    endfunction

    task automatic model_step();
        bit     ds;
        longint nxt;
        for (int i = 0; i < 2; i++) begin
            ds = (i == 0);
            if (!reset) begin
                m_phase[i] = 0;
                m_pc[i]    = RV;
                m_tgt[i]   = 32'd0;
                m_taken[i] = 1'b0;
                m_link[i]  = 32'd0;
                m_halt[i]  = 1'b0;
                rq[i].delete();
                if (ds) rq[i].push_back(-1);
            end else if (!stall) begin
                case (m_phase[i])
                    0: begin
                        if (m_pc[i] == 32'd0) begin
                            m_phase[i] = 3;
                            m_halt[i]  = 1'b1;
                        end else begin
                            m_phase[i] = 1;
                        end
                    end
                    1: begin
                        m_taken[i] = cond_taken(internal_code, zero, positive, negative);
                        m_tgt[i]   = target_of(internal_code, m_pc[i], offset, instr_index, register_data);
                        if (internal_code inside {7'd32, 7'd36, 7'd39, 7'd40})
                            m_link[i] = m_pc[i] + (ds ? 32'd8 : 32'd4);
                        m_phase[i] = 2;
                    end
                    2: begin
                        rq[i].push_back(m_taken[i] ? longint'(m_tgt[i]) : -1);
                        nxt        = rq[i].pop_front();
                        m_pc[i]    = (nxt < 0) ? m_pc[i] + 32'd4 : 32'(nxt);
                        m_taken[i] = 1'b0;
                        m_phase[i] = 0;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic compare_all();
        check_eq("ds1.address", address0, m_pc[0]);
        check_eq("ds1.fetch",   32'(fetch0), 32'(m_phase[0] == 0));
        check_eq("ds1.exec1",   32'(exec10), 32'(m_phase[0] == 1));
        check_eq("ds1.exec2",   32'(exec20), 32'(m_phase[0] == 2));
        check_eq("ds1.halt",    32'(halt0),  32'(m_halt[0]));
        check_eq("ds1.taken",   32'(taken0), 32'(m_taken[0]));
        check_eq("ds1.link",    link0,       m_link[0]);
        check_eq("ds0.address", address1, m_pc[1]);
        check_eq("ds0.fetch",   32'(fetch1), 32'(m_phase[1] == 0));
        check_eq("ds0.exec1",   32'(exec11), 32'(m_phase[1] == 1));
        check_eq("ds0.exec2",   32'(exec21), 32'(m_phase[1] == 2));
        check_eq("ds0.halt",    32'(halt1),  32'(m_halt[1]));
        check_eq("ds0.taken",   32'(taken1), 32'(m_taken[1]));
        check_eq("ds0.link",    link1,       m_link[1]);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // One instruction starting in FETCH, with optional stall cycles held in EXEC1.
    task automatic do_instr(input logic [6:0] code, input logic [15:0] off, input logic [25:0] idx,
                            input logic [31:0] rd, input logic z, input int stalls);
        internal_code = code;
        offset        = off;
        instr_index   = idx;
        register_data = rd;
        zero          = z;
        positive      = 1'b0;
        negative      = 1'b0;
        stall         = 1'b0;
        step();
        stall = 1'b1;
        repeat (stalls) step();
        stall = 1'b0;
        step();
        last_taken0 = taken0;
        step();
        internal_code = C_NOP;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; internal_code = C_NOP; offset = '0;
        instr_index = '0; register_data = '0; zero = 1'b0; positive = 1'b0; negative = 1'b0;
        last_taken0 = 1'b0;

        repeat (2) step();
        reset = 1'b1;
        check_eq("rst_address", address0, RV);
        check_eq("rst_fetch", 32'(fetch0), 32'd1);
        do_instr(C_NOP, 16'h0, 26'h0, 32'h0, 1'b0, 0);
        check_eq("seq_next", address0, 32'hBFC00004);

        do_instr(C_JR, 16'h0, 26'h0, 32'h100, 1'b0, 0);
        check_eq("jr_taken", 32'(last_taken0), 32'd1);
        check_eq("jr_slot", address0, 32'hBFC00008);
        check_eq("jr_ds0_direct", address1, 32'h100);
        do_instr(C_NOP, 16'h0, 26'h0, 32'h0, 1'b0, 0);
        check_eq("jr_target", address0, 32'h100);

        do_instr(C_BEQ, 16'h0010, 26'h0, 32'h0, 1'b1, 0);
        check_eq("beq_t_slot", address0, 32'h104);
        do_instr(C_NOP, 16'h0, 26'h0, 32'h0, 1'b0, 0);
        check_eq("beq_t_target", address0, 32'h144);

        do_instr(C_JR, 16'h0, 26'h0, 32'h100, 1'b0, 0);
        do_instr(C_NOP, 16'h0, 26'h0, 32'h0, 1'b0, 0);
        do_instr(C_BEQ, 16'h0010, 26'h0, 32'h0, 1'b0, 0);
        check_eq("beq_nt_taken", 32'(last_taken0), 32'd0);
        check_eq("beq_nt_1", address0, 32'h104);
        do_instr(C_NOP, 16'h0, 26'h0, 32'h0, 1'b0, 0);
        check_eq("beq_nt_2", address0, 32'h108);

        do_instr(C_JR, 16'h0, 26'h0, 32'h100, 1'b0, 0);
        do_instr(C_NOP, 16'h0, 26'h0, 32'h0, 1'b0, 0);
        do_instr(C_BEQ, 16'hFFFF, 26'h0, 32'h0, 1'b1, 0);
        do_instr(C_NOP, 16'h0, 26'h0, 32'h0, 1'b0, 0);
        check_eq("beq_back", address0, 32'h100);

        do_instr(C_JR, 16'h0, 26'h0, 32'h200, 1'b0, 0);
        do_instr(C_NOP, 16'h0, 26'h0, 32'h0, 1'b0, 0);
        check_eq("jal_pc", address0, 32'h200);
        do_instr(C_JAL, 16'h0, 26'h40, 32'h0, 1'b0, 0);
        check_eq("jal_link", link0, 32'h208);
        check_eq("jal_slot", address0, 32'h204);
        do_instr(C_NOP, 16'h0, 26'h0, 32'h0, 1'b0, 0);
        check_eq("jal_target", address0, 32'h100);

        reset = 1'b0; step(); reset = 1'b1;
        do_instr(C_JR, 16'h0, 26'h0, 32'h200, 1'b0, 0);
        check_eq("ds0_pc", address1, 32'h200);
        do_instr(C_JAL, 16'h0, 26'h40, 32'h0, 1'b0, 0);
        check_eq("ds0_link", link1, 32'h204);
        check_eq("ds0_target", address1, 32'h100);

        do_instr(C_JR, 16'h0, 26'h0, 32'h300, 1'b0, 0);
        do_instr(C_NOP, 16'h0, 26'h0, 32'h0, 1'b0, 0);
        do_instr(C_BNE, 16'h0008, 26'h0, 32'h0, 1'b0, 3);
        check_eq("bne_stall_slot", address0, 32'h304);
        do_instr(C_NOP, 16'h0, 26'h0, 32'h0, 1'b0, 0);
        check_eq("bne_stall_target", address0, 32'h324);

        do_instr(C_JR, 16'h0, 26'h0, 32'h0, 1'b0, 0);
        do_instr(C_NOP, 16'h0, 26'h0, 32'h0, 1'b0, 0);
        check_eq("halt_pc", address0, 32'h0);
        repeat (21) step();
        check_eq("halt_sticky", 32'(halt0), 32'd1);
        check_eq("halt_strobes", 32'({fetch0, exec10, exec20}), 32'd0);
        reset = 1'b0; step(); reset = 1'b1;
        check_eq("halt_rst_addr", address0, RV);
        check_eq("halt_rst_halt", 32'(halt0), 32'd0);

        // Random cycle-level stimulus; occasional resets, forced reset once both halt.
        for (int c = 0; c < 3000; c++) begin
            internal_code = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                        : 7'($urandom_range(30, 41));
            offset        = 16'($urandom);
            instr_index   = 26'($urandom);
            register_data = ($urandom_range(0, 99) == 0) ? 32'h0 : $urandom;
            zero          = 1'($urandom);
            positive      = 1'($urandom);
            negative      = 1'($urandom);
            stall         = ($urandom_range(0, 4) == 0);
            reset         = !(($urandom_range(0, 299) == 0) || (m_halt[0] && m_halt[1]));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
